// File: rtl/pipe_pkg.sv
// Shared types and per-boundary defaults for the elastic pipeline registers.
package pipe_pkg;

  // Occupancy of one elastic stage.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  // Per-slot command: bubble wins over load inside the slot.
  typedef struct packed {
    logic load;
    logic bubble;
  } slot_cmd_t;

  localparam slot_cmd_t SLOT_HOLD   = '{load: 1'b0, bubble: 1'b0};
  localparam slot_cmd_t SLOT_LOAD   = '{load: 1'b1, bubble: 1'b0};
  localparam slot_cmd_t SLOT_BUBBLE = '{load: 1'b0, bubble: 1'b1};

  // Default widths of a pipeline boundary.
  localparam int CTRL_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 160;

  // Bubble control words per boundary. A bubble must never write the
  // register file or memory, so all control-enable bits are zero.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE_DE = '0;
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE_EM = '0;
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE_MW = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus control and payload registers.
// Used twice per stage, once as the visible output slot, once as the skid.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                    CTRL_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 160,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter bit                    CLEAR_DATA  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  slot_cmd_t             cmd,
  input  logic [CTRL_WIDTH-1:0] ld_ctrl,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  // Reset clears everything; bubble kills the entry; load captures a new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
      data  <= '0;
    end else if (cmd.bubble) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
      if (CLEAR_DATA) data <= '0;
    end else if (cmd.load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-boundary register with a 2-entry skid, flush-to-bubble
// and a saturating stall counter. All outputs come straight from flops.
//
// state    | meaning
// ---------+-----------------------------------------
// PS_EMPTY | output slot invalid, skid invalid
// PS_FULL  | output slot valid, skid invalid
// PS_SKID  | output slot valid, skid valid (in_ready=0)
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                    CTRL_WIDTH  = CTRL_W_DEFAULT,
  parameter int                    DATA_WIDTH  = DATA_W_DEFAULT,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter bit                    CLEAR_DATA  = 1'b1,
  parameter int                    STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t           state;
  pipe_state_t           state_nxt;
  slot_cmd_t             out_cmd;
  slot_cmd_t             skid_cmd;
  logic                  out_from_skid;
  logic                  acc;
  logic                  take;
  logic                  skid_valid;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] out_ld_ctrl;
  logic [DATA_WIDTH-1:0] out_ld_data;

  assign acc  = in_valid && in_ready;
  assign take = out_valid && out_ready;

  // Output slot reloads from the skid when draining it, otherwise from upstream.
  assign out_ld_ctrl = out_from_skid ? skid_ctrl : in_ctrl;
  assign out_ld_data = out_from_skid ? skid_data : in_data;

  // Next-state and slot command decode; flush overrides every transfer.
  always_comb begin
    state_nxt     = state;
    out_cmd       = SLOT_HOLD;
    skid_cmd      = SLOT_HOLD;
    out_from_skid = 1'b0;
    if (flush) begin
      state_nxt = PS_EMPTY;
      out_cmd   = SLOT_BUBBLE;
      skid_cmd  = SLOT_BUBBLE;
    end else begin
      unique case (state)
        PS_EMPTY: begin
          if (acc) begin
            out_cmd   = SLOT_LOAD;
            state_nxt = PS_FULL;
          end
        end
        PS_FULL: begin
          if (take && acc) begin
            out_cmd = SLOT_LOAD;
          end else if (take) begin
            out_cmd   = SLOT_BUBBLE;
            state_nxt = PS_EMPTY;
          end else if (acc) begin
            skid_cmd  = SLOT_LOAD;
            state_nxt = PS_SKID;
          end
        end
        PS_SKID: begin
          if (take) begin
            out_cmd       = SLOT_LOAD;
            out_from_skid = 1'b1;
            skid_cmd      = SLOT_BUBBLE;
            state_nxt     = PS_FULL;
          end
        end
        default: begin
          state_nxt = PS_EMPTY;
          out_cmd   = SLOT_BUBBLE;
          skid_cmd  = SLOT_BUBBLE;
        end
      endcase
    end
  end

  // State register; in_ready is registered so upstream sees no combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PS_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != PS_SKID);
    end
  end

  // Saturating count of cycles where a valid output is held by downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_BUBBLE(CTRL_BUBBLE),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_out_slot (
    .clk    (clk),
    .rst    (rst),
    .cmd    (out_cmd),
    .ld_ctrl(out_ld_ctrl),
    .ld_data(out_ld_data),
    .valid  (out_valid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_BUBBLE(CTRL_BUBBLE),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid_slot (
    .clk    (clk),
    .rst    (rst),
    .cmd    (skid_cmd),
    .ld_ctrl(in_ctrl),
    .ld_data(in_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  // The slot valid flags and the state encoding must never disagree.
  a_ready_tracks_skid: assert property (@(posedge clk) disable iff (rst)
    in_ready == !skid_valid);
  a_valid_tracks_state: assert property (@(posedge clk) disable iff (rst)
    out_valid == (state != PS_EMPTY));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_stage_elastic;

  localparam int              CW  = 8;
  localparam int              DW  = 32;
  localparam int              SW  = 4;
  localparam logic [CW-1:0]   BUB = 8'hA5;
  localparam int              CNT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .CTRL_WIDTH (CW),
    .DATA_WIDTH (DW),
    .CTRL_BUBBLE(BUB),
    .CLEAR_DATA (1'b1),
    .STALL_CNT_W(SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two entries.
  always @(posedge clk) begin
    bit can_take, can_acc;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        can_take = (q.size() > 0) && out_ready;
        can_acc  = in_valid && (q.size() < 2);
        if (can_take) void'(q.pop_front());
        if (can_acc) q.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  // Every-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (q.size() > 0) begin
        chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        chk("out_data", 64'(out_data), 64'(q[0].d));
      end else begin
        chk("bubble_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("bubble_data", 64'(out_data), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input bit v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = d[CW-1:0] ^ 8'h3C;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; put(1'b0, '0); out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    step();
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'hA5);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    // Stream 1..8 at full rate, one cycle latency.
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, DW'(i));
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ctrl", 64'(out_ctrl), 64'(i ^ 8'h3C));
    end
    put(1'b0, '0);
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Skid fill and drain.
    do_reset();
    put(1'b1, 32'hA); step();
    out_ready = 1'b0; put(1'b1, 32'hB); step();
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head", 64'(out_data), 64'hA);
    put(1'b0, '0); out_ready = 1'b1; step();
    chk("skid_second", 64'(out_data), 64'hB);
    step();
    chk("skid_empty", 64'(out_valid), 64'd0);
    chk("skid_stall", 64'(stall_cnt), 64'd1);

    // Flush while in SKID.
    put(1'b1, 32'hA); step();
    out_ready = 1'b0; put(1'b1, 32'hB); step();
    put(1'b0, '0); flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'hA5);
    chk("flush_data", 64'(out_data), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Flush discards a same-cycle accept.
    out_ready = 1'b1;
    put(1'b1, 32'hC); flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_acc_dropped", 64'(out_valid), 64'd0);
    put(1'b1, 32'hD); step();
    chk("after_flush_data", 64'(out_data), 64'hD);
    put(1'b0, '0); step();

    // Stall counter saturation, then reset clears it.
    do_reset();
    out_ready = 1'b0; put(1'b1, 32'h11); step();
    put(1'b0, '0);
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", 64'(stall_cnt), 64'hF);
    chk("stall_hold_data", 64'(out_data), 64'h11);
    do_reset();
    chk("stall_cleared", 64'(stall_cnt), 64'd0);

    // Reset in the middle of a stream.
    for (int i = 1; i <= 5; i++) begin
      put(1'b1, DW'(i)); step();
    end
    chk("mid_before", 64'(out_data), 64'h5);
    rst = 1'b1; put(1'b1, 32'h6); step();
    rst = 1'b0; put(1'b0, '0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    // Random traffic with varying downstream pressure.
    for (int ph = 0; ph < 10; ph++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int k = 0; k < 300; k++) begin
        rst       = ($urandom_range(0, 299) == 0);
        flush     = ($urandom_range(0, 39) == 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(1, 100) <= rdy_pct);
        in_ctrl   = CW'($urandom);
        in_data   = $urandom;
        step();
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
